// File: rtl/write_back_stage.sv
// Final pipeline stage: selects ALU/PC/load data, formats loads, drives the
// register-file write port. Optional retire counter under WB_RETIRE_COUNTER_EN.
module write_back_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int PC_INCR    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_write_enable,
  input  logic [REG_ADDR_W-1:0] in_addr_rd,
  input  logic [1:0]            in_store_sel,
  input  logic [XLEN-1:0]       in_alu_result,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [2:0]            in_load_funct3,
  input  logic [1:0]            in_load_offset,
  input  logic [XLEN-1:0]       mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  wb_busy,
  output logic                  retire
`ifdef WB_RETIRE_COUNTER_EN
  ,
  output logic [63:0]           instret,
  input  logic                  instret_inhibit
`endif
);

  typedef enum logic {
    IDLE,
    WAIT_MEM
  } state_t;

  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_PC  = 2'd2;

  state_t                  state;
  logic                    pend_we;
  logic [REG_ADDR_W-1:0]   pend_rd;
  logic [2:0]              pend_funct3;
  logic [1:0]              pend_offset;

  logic                    accept;
  logic                    accept_load;
  logic                    wr_fire;
  logic                    wr_en;
  logic [REG_ADDR_W-1:0]   wr_addr;
  logic [XLEN-1:0]         wr_data;

  // Byte lane follows the full offset; half lane uses only offset[1].
  function automatic logic [XLEN-1:0] format_load(input logic [XLEN-1:0] word,
                                                  input logic [2:0]      funct3,
                                                  input logic [1:0]      offset);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{offset, 3'b000} +: 8];
    h = word[{offset[1], 4'b0000} +: 16];
    case (funct3)
      3'b000:  return {{(XLEN-8){b[7]}}, b};
      3'b100:  return {{(XLEN-8){1'b0}}, b};
      3'b001:  return {{(XLEN-16){h[15]}}, h};
      3'b101:  return {{(XLEN-16){1'b0}}, h};
      default: return word;
    endcase
  endfunction

  assign in_ready    = reset && (state == IDLE);
  assign wb_busy     = (state == WAIT_MEM);
  assign accept      = in_valid && in_ready;
  assign accept_load = accept && (in_store_sel == SEL_MEM);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    wr_fire = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (accept && !accept_load) begin
      wr_fire = 1'b1;
      wr_en   = in_write_enable;
      wr_addr = in_addr_rd;
      wr_data = (in_store_sel == SEL_PC) ? in_pc + XLEN'(PC_INCR) : in_alu_result;
    end else if (state == WAIT_MEM && mem_rvalid) begin
      wr_fire = 1'b1;
      wr_en   = pend_we;
      wr_addr = pend_rd;
      wr_data = format_load(mem_rdata, pend_funct3, pend_offset);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state    <= IDLE;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      retire   <= 1'b0;
    end else begin
      rf_we  <= wr_fire && wr_en && (wr_addr != '0);
      retire <= wr_fire;
      if (wr_fire) begin
        rf_waddr <= wr_addr;
        rf_wdata <= wr_data;
      end
      case (state)
        IDLE:     if (accept_load) state <= WAIT_MEM;
        WAIT_MEM: if (mem_rvalid)  state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // NOTE: pending-load fields need no reset; they are only read in WAIT_MEM, after being loaded.
  always_ff @(posedge clk) begin
    if (accept_load) begin
      pend_we     <= in_write_enable;
      pend_rd     <= in_addr_rd;
      pend_funct3 <= in_load_funct3;
      pend_offset <= in_load_offset;
    end
  end

`ifdef WB_RETIRE_COUNTER_EN
  logic [63:0] instret_q;

  // Counts on the same edge that raises retire, so instret is current while retire is high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      instret_q <= '0;
    end else if (wr_fire && !instret_inhibit) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_write_back_stage.sv
// Directed bench for write_back_stage: ALU/PC/load paths, x0 rule, wait-state
// handshake, reset during a pending load, and the optional retire counter.
module tb_write_back_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_write_enable;
  logic [4:0]  in_addr_rd;
  logic [1:0]  in_store_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc;
  logic [2:0]  in_load_funct3;
  logic [1:0]  in_load_offset;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_busy;
  logic        retire;
`ifdef WB_RETIRE_COUNTER_EN
  logic [63:0] instret;
  logic        instret_inhibit;
`endif

  int vectors     = 0;
  int miscompares = 0;

  write_back_stage dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_write_enable (in_write_enable),
    .in_addr_rd      (in_addr_rd),
    .in_store_sel    (in_store_sel),
    .in_alu_result   (in_alu_result),
    .in_pc           (in_pc),
    .in_load_funct3  (in_load_funct3),
    .in_load_offset  (in_load_offset),
    .mem_rdata       (mem_rdata),
    .mem_rvalid      (mem_rvalid),
    .rf_we           (rf_we),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .wb_busy         (wb_busy),
    .retire          (retire)
`ifdef WB_RETIRE_COUNTER_EN
    ,
    .instret         (instret),
    .instret_inhibit (instret_inhibit)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc,
                       input logic [2:0] f3, input logic [1:0] off);
    in_valid        = 1'b1;
    in_write_enable = we;
    in_addr_rd      = rd;
    in_store_sel    = sel;
    in_alu_result   = alu;
    in_pc           = pc;
    in_load_funct3  = f3;
    in_load_offset  = off;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [1:0] off,
                         input int delay, input logic [31:0] expected);
    mem_rdata = 32'h80FF7F01;
    issue(1'b1, 5'd9, 2'd1, 32'h0, 32'h0, f3, off);
    check({tag, " wait busy"},  {63'd0, wb_busy},  64'd1);
    check({tag, " wait ready"}, {63'd0, in_ready}, 64'd0);
    check({tag, " wait we"},    {63'd0, rf_we},    64'd0);
    for (int i = 0; i < delay; i++) begin
      step();
      check({tag, " held busy"},  {63'd0, wb_busy},  64'd1);
      check({tag, " held ready"}, {63'd0, in_ready}, 64'd0);
    end
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    check({tag, " we"},     {63'd0, rf_we},    64'd1);
    check({tag, " waddr"},  {59'd0, rf_waddr}, 64'd9);
    check({tag, " wdata"},  {32'd0, rf_wdata}, {32'd0, expected});
    check({tag, " retire"}, {63'd0, retire},   64'd1);
    check({tag, " ready"},  {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    reset           = 1'b0;
    in_valid        = 1'b0;
    in_write_enable = 1'b0;
    in_addr_rd      = '0;
    in_store_sel    = '0;
    in_alu_result   = '0;
    in_pc           = '0;
    in_load_funct3  = '0;
    in_load_offset  = '0;
    mem_rdata       = '0;
    mem_rvalid      = 1'b0;
`ifdef WB_RETIRE_COUNTER_EN
    instret_inhibit = 1'b0;
`endif

    step();
    step();
    check("reset we",    {63'd0, rf_we},    64'd0);
    check("reset waddr", {59'd0, rf_waddr}, 64'd0);
    check("reset wdata", {32'd0, rf_wdata}, 64'd0);
    check("reset retire",{63'd0, retire},   64'd0);
    check("reset busy",  {63'd0, wb_busy},  64'd0);
    check("reset ready", {63'd0, in_ready}, 64'd0);
    reset = 1'b1;
    #1;
    check("ready after reset", {63'd0, in_ready}, 64'd1);

    // ALU write, then confirm the single-cycle pulse.
    issue(1'b1, 5'd5, 2'd0, 32'h12345678, 32'h0, 3'd0, 2'd0);
    check("alu we",     {63'd0, rf_we},    64'd1);
    check("alu waddr",  {59'd0, rf_waddr}, 64'd5);
    check("alu wdata",  {32'd0, rf_wdata}, 64'h12345678);
    check("alu retire", {63'd0, retire},   64'd1);
    step();
    check("alu we drop",     {63'd0, rf_we},  64'd0);
    check("alu retire drop", {63'd0, retire}, 64'd0);

    issue(1'b1, 5'd1, 2'd2, 32'h0, 32'h00000100, 3'd0, 2'd0);
    check("jal wdata", {32'd0, rf_wdata}, 64'h00000104);
    check("jal waddr", {59'd0, rf_waddr}, 64'd1);
    issue(1'b1, 5'd1, 2'd2, 32'h0, 32'hFFFFFFFC, 3'd0, 2'd0);
    check("jal wrap wdata", {32'd0, rf_wdata}, 64'h00000000);
    check("jal wrap we",    {63'd0, rf_we},    64'd1);
    issue(1'b1, 5'd3, 2'd3, 32'hCAFEF00D, 32'h00000200, 3'd0, 2'd0);
    check("reserved sel wdata", {32'd0, rf_wdata}, 64'hCAFEF00D);

    // mem_rvalid in IDLE must not produce a write.
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    check("idle rvalid we",     {63'd0, rf_we},  64'd0);
    check("idle rvalid retire", {63'd0, retire}, 64'd0);

    do_load("lb off3",  3'b000, 2'd3, 0, 32'hFFFFFF80);
    do_load("lbu off3", 3'b100, 2'd3, 0, 32'h00000080);
    do_load("lh off2",  3'b001, 2'd2, 3, 32'hFFFF80FF);
    do_load("lhu off0", 3'b101, 2'd0, 0, 32'h00007F01);
    do_load("lh off3",  3'b001, 2'd3, 1, 32'hFFFF80FF);
    do_load("lb off1",  3'b000, 2'd1, 0, 32'h0000007F);
    do_load("lw off1",  3'b010, 2'd1, 0, 32'h80FF7F01);
    do_load("undef 011",3'b011, 2'd2, 0, 32'h80FF7F01);

    // x0 destination and store-class instruction: retire without a write.
    issue(1'b1, 5'd0, 2'd0, 32'hDEADBEEF, 32'h0, 3'd0, 2'd0);
    check("x0 we",     {63'd0, rf_we},    64'd0);
    check("x0 retire", {63'd0, retire},   64'd1);
    check("x0 wdata",  {32'd0, rf_wdata}, 64'hDEADBEEF);
    issue(1'b0, 5'd7, 2'd0, 32'h00000042, 32'h0, 3'd0, 2'd0);
    check("store we",     {63'd0, rf_we},    64'd0);
    check("store retire", {63'd0, retire},   64'd1);
    check("store waddr",  {59'd0, rf_waddr}, 64'd7);

    // Reset while a load is pending drops it.
    issue(1'b1, 5'd12, 2'd1, 32'h0, 32'h0, 3'b010, 2'd0);
    check("pre-reset busy", {63'd0, wb_busy}, 64'd1);
    reset      = 1'b0;
    mem_rvalid = 1'b1;
    step();
    check("mid reset we",     {63'd0, rf_we},    64'd0);
    check("mid reset retire", {63'd0, retire},   64'd0);
    check("mid reset busy",   {63'd0, wb_busy},  64'd0);
    check("mid reset ready",  {63'd0, in_ready}, 64'd0);
    reset = 1'b1;
    step();
    mem_rvalid = 1'b0;
    check("late rvalid we",     {63'd0, rf_we},    64'd0);
    check("late rvalid retire", {63'd0, retire},   64'd0);
    check("post reset ready",   {63'd0, in_ready}, 64'd1);
    check("post reset busy",    {63'd0, wb_busy},  64'd0);

`ifdef WB_RETIRE_COUNTER_EN
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("instret reset", instret, 64'd0);
    for (int i = 0; i < 10; i++) issue(1'b1, 5'd2, 2'd0, i, 32'h0, 3'd0, 2'd0);
    check("instret ten", instret, 64'd10);

    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      instret_inhibit = (i >= 4 && i < 7);
      issue(1'b1, 5'd2, 2'd0, i, 32'h0, 3'd0, 2'd0);
    end
    instret_inhibit = 1'b0;
    check("instret inhibited", instret, 64'd7);

    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    check("instret preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(1'b1, 5'd2, 2'd0, 32'h1, 32'h0, 3'd0, 2'd0);
    check("instret wrap", instret, 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/write_back_stage.md
Name: write_back_stage

Overview:
- Final pipeline stage. Consumes the decoded write-back controls (write enable, rd address, write-back source select) and the ALU result, PC and memory read data, and produces the single register-file write port.
- Holds a load in a wait state until memory returns data, then formats and sign/zero-extends it.
- Provides a registered forwarding copy of each write and a retire pulse.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register address width.
- PC_INCR, 4, link offset added to PC for JAL/JALR.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  stage can accept an instruction this cycle.
- in_write_enable  input  1  decoded register-file write enable.
- in_addr_rd  input  REG_ADDR_W  destination register.
- in_store_sel  input  2  write-back source: 0=ALU, 1=MEM, 2=PC, 3=reserved.
- in_alu_result  input  XLEN  ALU output.
- in_pc  input  XLEN  instruction PC.
- in_load_funct3  input  3  load funct3.
- in_load_offset  input  2  byte address [1:0] of the load.
- mem_rdata  input  XLEN  memory read word.
- mem_rvalid  input  1  memory read data valid.
- rf_we  output  1  register-file write strobe.
- rf_waddr  output  REG_ADDR_W  write address.
- rf_wdata  output  XLEN  write data.
- wb_busy  output  1  stage is in WAIT_MEM; used by the hazard unit.
- retire  output  1  one-cycle pulse per completed instruction.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE.
  - rf_we=0, rf_waddr=0, rf_wdata=0, retire=0, wb_busy=0.
  - in_ready=0 while reset is low.
- Handshake: an instruction is accepted when in_valid && in_ready at a clk edge.
- in_ready=1 in IDLE and 0 in WAIT_MEM. This is combinational from state only, never from in_valid.
- FSM state IDLE:
  - Accepted instruction with in_store_sel!=1: stay in IDLE and register the result.
    - rf_we/rf_waddr/rf_wdata/retire are valid in the cycle after acceptance (1-cycle latency).
    - rf_we and retire are single-cycle pulses.
  - Accepted instruction with in_store_sel==1: latch addr_rd, write_enable, funct3 and offset, then move to WAIT_MEM.
  - mem_rvalid is ignored in IDLE.
- FSM state WAIT_MEM:
  - wb_busy=1.
  - On mem_rvalid=1: format the data, register the write for the next cycle, pulse retire, and return to IDLE.
  - in_ready rises in that same next cycle, so back-to-back loads are legal.
- Data select:
  - ALU or reserved (3): in_alu_result.
  - PC: in_pc + PC_INCR, wrapping modulo 2^XLEN (0xFFFFFFFC -> 0x00000000).
- Load formatting:
  - Byte lane = offset. Half lane = offset[1]; offset[0] is ignored for halves.
  - LB (000): sign-extend the byte.
  - LBU (100): zero-extend the byte.
  - LH (001): sign-extend the half.
  - LHU (101): zero-extend the half.
  - LW (010): full word, offset ignored.
  - Undefined funct3 (011, 110, 111) is treated as LW.
- x0 rule: if rd==0 or write_enable==0, rf_we stays 0. retire still pulses and rf_waddr/rf_wdata still update.
- Reset mid-WAIT_MEM: the pending load is dropped, with no write and no retire. A mem_rvalid arriving after reset has no effect.
- rf_we is never asserted in the same cycle as reset low.

Optional Feature:
- Macro WB_RETIRE_COUNTER_EN.
- When defined:
  - Adds output instret, 64 bits.
  - Counter cleared on reset, incremented by 1 in the cycle each retire pulse is issued, wrapping 2^64-1 -> 0.
  - Adds input instret_inhibit, 1 bit: when high, the counter holds.
- When undefined: no instret or instret_inhibit ports, no counter logic. All other behaviour is identical.

Test Plan:
- ALU op: rd=5, alu=0x12345678, sel=0 accepted -> next cycle rf_we=1, waddr=5, wdata=0x12345678, retire=1; the cycle after, rf_we=0.
- JAL: sel=2, pc=0x00000100, rd=1 -> wdata=0x00000104. Wrap case: pc=0xFFFFFFFC -> wdata=0x00000000.
- LB with mem_rdata=0x80FF7F01:
  - offset=3 -> 0xFFFFFF80.
  - LBU offset=3 -> 0x00000080.
  - LH offset=2 -> 0xFFFF80FF.
  - LHU offset=0 -> 0x00007F01.
  - mem_rvalid 3 cycles after acceptance -> in_ready=0 and wb_busy=1 for those cycles, then write.
- rd=0, alu=0xDEADBEEF -> rf_we stays 0, retire=1. Store-class instruction (write_enable=0) -> rf_we=0, retire=1.
- Load accepted, reset low during WAIT_MEM, then mem_rvalid=1 -> no rf_we, no retire, state IDLE, in_ready=1 after reset releases.
- With WB_RETIRE_COUNTER_EN defined:
  - 10 retiring instructions -> instret=10.
  - instret_inhibit high during 3 of them -> instret=7.
  - Counter preloaded to 2^64-1 (forced) -> next retire gives instret=0.
